weight_loader: RTL and testbench

Upstream stage of the on-chip MLP: receives a byte stream of network weights over a valid/ready handshake, buffers it in shadow registers, verifies an XOR checksum, and atomically commits the result to the active weight bus. The active bus drives the `w*_i` inputs of the hidden-layer and output neurons, replacing hard-wired constants. A failed checksum leaves the active weights untouched.

---
 rtl/weight_loader.sv | 121 ++++++++++++
 tb/tb_weight_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// weight_loader: receives a weight frame over valid/ready, stages it in shadow
// registers, checks the XOR checksum and commits all weights atomically.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no load in progress, active weights stable
// S_LOAD | accepting weight bytes, then the checksum byte
// S_ERR  | last frame failed its checksum, error_o held until next start
module weight_loader #(
    parameter int N_HIDDEN = 8,
    parameter int N_IN     = 4,
    parameter int W_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             load_start_i,
    input  logic                             data_valid_i,
    input  logic [W_WIDTH-1:0]               data_i,
    output logic                             data_ready_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic [5:0]                       byte_cnt_o,
    output logic [N_HIDDEN*N_IN*W_WIDTH-1:0] hidden_w_o,
    output logic [N_HIDDEN*W_WIDTH-1:0]      out_w_o
);

    localparam int         NH   = N_HIDDEN * N_IN;
    localparam int         NW   = NH + N_HIDDEN;
    localparam int         BITS = NW * W_WIDTH;
    localparam logic [5:0] NW_C = 6'(NW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [W_WIDTH-1:0]  csum_q, csum_d;
    logic [BITS-1:0]     shadow_q, shadow_d;
    logic [BITS-1:0]     act_q, act_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic start;
    logic accept;

    // A start request outranks a byte presented in the same cycle.
    assign start  = en_i & load_start_i;
    assign accept = (state_q == S_LOAD) & en_i & data_valid_i & ~load_start_i;

    // Next-state logic for the loader FSM, staging and commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (start) begin
            state_d = S_LOAD;
            cnt_d   = 6'd0;
            csum_d  = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (cnt_q == NW_C) begin
                cnt_d = 6'd0;
                if (data_i == csum_q) begin
                    act_d   = shadow_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end else begin
                for (int k = 0; k < NW; k++) begin
                    if (cnt_q == 6'(k)) begin
                        shadow_d[k*W_WIDTH +: W_WIDTH] = data_i;
                    end
                end
                csum_d = csum_q ^ data_i;
                cnt_d  = cnt_q + 6'd1;
            end
        end
    end

    // State registers; reset clears active weights as well as the shadow copy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            csum_q   <= '0;
            shadow_q <= '0;
            act_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign data_ready_o = (state_q == S_LOAD) & en_i;
    assign busy_o       = (state_q == S_LOAD);
    assign done_o       = done_q;
    assign error_o      = err_q;
    assign byte_cnt_o   = cnt_q;
    assign hidden_w_o   = act_q[NH*W_WIDTH-1:0];
    assign out_w_o      = act_q[BITS-1:NH*W_WIDTH];

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader at default parameters.
module tb_weight_loader;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         load_start_i;
    logic         data_valid_i;
    logic [7:0]   data_i;
    logic         data_ready_o;
    logic         busy_o;
    logic         done_o;
    logic         error_o;
    logic [5:0]   byte_cnt_o;
    logic [255:0] hidden_w_o;
    logic [63:0]  out_w_o;

    int n_tests = 0;
    int n_fail  = 0;

    weight_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .load_start_i (load_start_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .byte_cnt_o   (byte_cnt_o),
        .hidden_w_o   (hidden_w_o),
        .out_w_o      (out_w_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        load_start_i = 1'b1;
        data_valid_i = 1'b0;
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        data_i       = b;
        data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
    endtask

    // Streams 40 weight bytes (base + k + 1) then the checksum byte.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] csum, input bit stall);
        for (int k = 0; k < 40; k++) begin
            if (stall) begin
                int idle;
                idle = $urandom_range(0, 2);
                data_i = base + 8'(k + 1);
                for (int i = 0; i < idle; i++) tick();
                if (k == 15) begin
                    en_i         = 1'b0;
                    data_valid_i = 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        tick();
                        chk("en_low_cnt_hold", 64'(byte_cnt_o), 64'd15);
                    end
                    chk("en_low_ready", 64'(data_ready_o), 64'd0);
                    en_i = 1'b1;
                end
            end
            push(base + 8'(k + 1));
        end
        chk("cnt_at_nw", 64'(byte_cnt_o), 64'd40);
        chk("no_done_before_csum", 64'(done_o), 64'd0);
        push(csum);
    endtask

    initial begin
        rst_i        = 1'b0;
        en_i         = 1'b1;
        load_start_i = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 8'h00;
        #12;
        chk("rst_ready", 64'(data_ready_o), 64'd0);
        chk("rst_busy",  64'(busy_o),       64'd0);
        chk("rst_done",  64'(done_o),       64'd0);
        chk("rst_err",   64'(error_o),      64'd0);
        chk("rst_cnt",   64'(byte_cnt_o),   64'd0);
        chk("rst_hid",   hidden_w_o[63:0],  64'd0);
        chk("rst_out",   out_w_o,           64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // Bytes offered in IDLE are ignored; start is ignored while disabled.
        push(8'h55);
        chk("idle_ignore_cnt", 64'(byte_cnt_o), 64'd0);
        en_i = 1'b0;
        do_start();
        chk("start_while_disabled", 64'(busy_o), 64'd0);
        en_i = 1'b1;

        // Scenario 1: good frame.
        do_start();
        chk("s1_ready", 64'(data_ready_o), 64'd1);
        chk("s1_busy",  64'(busy_o),       64'd1);
        send_frame(8'h00, 8'h28, 1'b0);
        chk("s1_done",     64'(done_o),         64'd1);
        chk("s1_hid_lo",   64'(hidden_w_o[7:0]),    64'h01);
        chk("s1_hid_hi",   64'(hidden_w_o[255:248]), 64'h20);
        chk("s1_out_lo",   64'(out_w_o[7:0]),       64'h21);
        chk("s1_out_hi",   64'(out_w_o[63:56]),     64'h28);
        chk("s1_err",      64'(error_o),        64'd0);
        chk("s1_cnt_wrap", 64'(byte_cnt_o),     64'd0);
        chk("s1_idle",     64'(busy_o),         64'd0);
        tick();
        chk("s1_done_one_cycle", 64'(done_o), 64'd0);

        // Scenario 2: bad checksum keeps the old weights.
        do_start();
        send_frame(8'h00, 8'h00, 1'b0);
        chk("s2_err",     64'(error_o), 64'd1);
        chk("s2_no_done", 64'(done_o),  64'd0);
        chk("s2_busy",    64'(busy_o),  64'd0);
        chk("s2_hid_kept", 64'(hidden_w_o[7:0]), 64'h01);
        chk("s2_out_kept", 64'(out_w_o[63:56]),  64'h28);
        push(8'h77);
        chk("s2_err_ignore_cnt", 64'(byte_cnt_o), 64'd0);
        chk("s2_err_sticky",     64'(error_o),    64'd1);
        do_start();
        chk("s2_err_cleared", 64'(error_o), 64'd0);
        chk("s2_restart_busy", 64'(busy_o), 64'd1);

        // Scenario 3: stalls and an enable drop mid-frame.
        send_frame(8'h00, 8'h28, 1'b1);
        chk("s3_done",   64'(done_o), 64'd1);
        chk("s3_hid_lo", 64'(hidden_w_o[7:0]),    64'h01);
        chk("s3_hid_hi", 64'(hidden_w_o[255:248]), 64'h20);
        chk("s3_out_hi", 64'(out_w_o[63:56]),     64'h28);

        // Scenario 4: restart with a concurrent byte, then a different frame.
        do_start();
        for (int k = 0; k < 10; k++) push(8'(k + 1));
        chk("s4_cnt10", 64'(byte_cnt_o), 64'd10);
        load_start_i = 1'b1;
        data_valid_i = 1'b1;
        data_i       = 8'hEE;
        tick();
        load_start_i = 1'b0;
        data_valid_i = 1'b0;
        chk("s4_restart_cnt",  64'(byte_cnt_o), 64'd0);
        chk("s4_restart_busy", 64'(busy_o),     64'd1);
        send_frame(8'h80, 8'h28, 1'b0);
        chk("s4_done",   64'(done_o), 64'd1);
        chk("s4_hid_lo", 64'(hidden_w_o[7:0]),    64'h81);
        chk("s4_hid_hi", 64'(hidden_w_o[255:248]), 64'hA0);
        chk("s4_out_lo", 64'(out_w_o[7:0]),       64'hA1);
        chk("s4_out_hi", 64'(out_w_o[63:56]),     64'hA8);

        // Scenario 5: asynchronous reset partway through a frame.
        do_start();
        for (int k = 0; k < 20; k++) push(8'(k + 1));
        #2;
        rst_i = 1'b0;
        #1;
        chk("s5_ready", 64'(data_ready_o), 64'd0);
        chk("s5_busy",  64'(busy_o),       64'd0);
        chk("s5_cnt",   64'(byte_cnt_o),   64'd0);
        chk("s5_err",   64'(error_o),      64'd0);
        chk("s5_hid",   hidden_w_o[63:0],  64'd0);
        chk("s5_out",   out_w_o,           64'd0);
        #1;
        rst_i = 1'b1;
        tick();
        do_start();
        send_frame(8'h00, 8'h28, 1'b0);
        chk("s5_done",   64'(done_o), 64'd1);
        chk("s5_hid_lo", 64'(hidden_w_o[7:0]), 64'h01);
        chk("s5_out_hi", 64'(out_w_o[63:56]),  64'h28);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
